// File: rtl/mux_rr_arbiter.sv
// Round-robin 2:1 arbiter with burst limit feeding a one-entry
// valid/ready output register; sel steers the shared data mux.
module mux_rr_arbiter #(
    parameter int WIDTH     = 5,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic gnt_a, gnt_b, load, fire_a, fire_b, under;

    assign under = cnt_q < CMAX;

    // Grants are suppressed while reset is sampled so nothing is accepted.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            unique case (state_q)
                OWN_A: begin
                    if (a_valid && (!b_valid || under)) gnt_a = 1'b1;
                    else if (b_valid)                   gnt_b = 1'b1;
                end
                OWN_B: begin
                    if (b_valid && (!a_valid || under)) gnt_b = 1'b1;
                    else if (a_valid)                   gnt_a = 1'b1;
                end
                default: begin
                    if (a_valid && b_valid) begin
                        gnt_a = last_q;
                        gnt_b = ~last_q;
                    end else begin
                        gnt_a = a_valid;
                        gnt_b = b_valid;
                    end
                end
            endcase
        end
    end

    assign load      = ~valid_q | out_ready;
    assign a_ready   = load & gnt_a;
    assign b_ready   = load & gnt_b;
    assign fire_a    = a_valid & a_ready;
    assign fire_b    = b_valid & b_ready;
    assign sel       = gnt_b | (~gnt_a & sel_q);
    assign out_data  = data_q;
    assign out_valid = valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (fire_a || fire_b) begin
            data_d  = sel ? b_data : a_data;
            valid_d = 1'b1;
            state_d = fire_b ? OWN_B : OWN_A;
            last_d  = fire_b;
            sel_d   = fire_b;
            if ((fire_a && state_q == OWN_A) ||
                (fire_b && state_q == OWN_B)) begin
                cnt_d = under ? cnt_q + CW'(1) : cnt_q;
            end else begin
                cnt_d = CW'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (!a_valid && !b_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule
